imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the ID stage of the 5-stage MIPS pipeline.
//  Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes:
//    sign-extend, zero-extend, LUI upper-placement, branch offset (sign-extend then << BR_SHIFT).
//  Sits between decode and the ID/EX register behind a 2-entry skid buffer.
//  The skid buffer gives valid/ready backpressure, stall hold and flush without a combinational ready path.
// PARAMETERS
//  IN_W      16  immediate input width
//  OUT_W     32  extended output width
//  BR_SHIFT  2   left shift applied in branch mode
//  TAG_W     5   sideband tag (e.g. rt/rd index) carried alongside, unmodified
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  flush      in   1          synchronous squash of all held entries (branch taken / exception)
//  in_valid   in   1          upstream offers imm/mode/tag
//  in_ready   out  1          block can accept this cycle (registered)
//  in_imm     in   IN_W       raw immediate
//  in_mode    in   2          00 SIGN, 01 ZERO, 10 LUI, 11 BRANCH
//  in_tag     in   TAG_W      sideband, passed through
//  out_valid  out  1          out_data/out_tag valid
//  out_ready  in   1          downstream accepts
//  out_data   out  OUT_W      extended immediate
//  out_tag    out  TAG_W      tag of the same entry
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, out_tag=0, skid empty, in_ready=1.
//  Arithmetic, computed combinationally on the input side; the result is registered:
//   SIGN   {(OUT_W-IN_W){imm[IN_W-1]}, imm}
//   ZERO   {(OUT_W-IN_W){1'b0}, imm}
//   LUI    {imm, (OUT_W-IN_W){1'b0}}
//   BRANCH SIGN result << BR_SHIFT; vacated LSBs are 0.
//  Elaboration check: OUT_W >= IN_W+BR_SHIFT and OUT_W > IN_W, else $error.
//  Handshake:
//   - accept when in_valid & in_ready
//   - transfer out when out_valid & out_ready
//   - in_ready is a flop equal to ~skid_valid
//   - once presented, out_valid/out_data/out_tag hold stable until taken
//  Latency: 1 cycle from accept to out_valid, with FIFO order preserved.
//  States (main/skid valid bits):
//   EMPTY: accept -> ONE
//   ONE:   accept&~take -> TWO (new entry lands in skid)
//          take&~accept -> EMPTY
//          accept&take  -> ONE (main reloaded)
//   TWO:   in_ready=0, no accept
//          take -> ONE (skid moves into main, same cycle)
//  Boundaries:
//   - flush has priority over a simultaneous accept/take: next cycle EMPTY, out_valid=0, in_ready=1.
//     The data regs may keep stale values.
//   - in_valid while in_ready=0: ignored; upstream must hold.
//   - reset mid-operation: immediate return to reset values; no entry survives.
//   - out_ready toggling while out_valid=0 has no effect.
// STRUCTURE
//  Package imm_ext_pkg: localparams MODE_SIGN=2'b00, MODE_ZERO=2'b01, MODE_LUI=2'b10, MODE_BRANCH=2'b11;
//   state encoding EMPTY/ONE/TWO.
//  Sub-module imm_ext_core (combinational, IN_W/OUT_W/BR_SHIFT): mode mux producing the OUT_W result.
//  Top: imm_ext_core feeding main + skid registers and the 3-state control.
// TESTING
//  1. in_imm=16'h8004 through all modes, out_ready=1:
//     SIGN 32'hFFFF8004, ZERO 32'h00008004, LUI 32'h80040000, BRANCH 32'hFFFE0010.
//  2. BRANCH 16'hFFFF -> 32'hFFFFFFFC; SIGN 16'h7FFF -> 32'h00007FFF.
//     Out on the cycle after accept, back-to-back at 1/cycle.
//  3. out_ready=0, offer A,B,C on consecutive cycles:
//     A,B accepted; in_ready=0 from cycle 2; C held.
//     Raise out_ready -> A,B,C emerge in order, no loss or duplication.
//  4. State TWO with flush=1 and in_valid=1 in the same cycle:
//     next cycle out_valid=0, in_ready=1, new entry not captured.
//  5. rst_n low for 1 cycle while in TWO: out_valid=0, out_data=0, in_ready=1 asynchronously.
//     The first post-reset accept emerges after 1 cycle.
//  6. Random valid/ready/mode over 10k cycles vs a reference queue model:
//     data/tag match, and out_data stays stable while out_valid&~out_ready.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode codes and skid-buffer state encoding for imm_extend_pipe
package imm_ext_pkg;
   localparam logic [1:0] MODE_SIGN   = 2'b00;
   localparam logic [1:0] MODE_ZERO   = 2'b01;
   localparam logic [1:0] MODE_LUI    = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate widener (sign / zero / lui / branch offset)
//   imm  in  IN_W   raw immediate
//   mode in  2      imm_ext_pkg MODE_* code
//   ext  out OUT_W  extended result
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext
);
   if (OUT_W < IN_W + BR_SHIFT || OUT_W <= IN_W) begin : g_bad_widths
      $error("imm_ext_core: OUT_W must exceed IN_W and hold IN_W+BR_SHIFT bits");
   end
   logic [OUT_W-1:0] sx, zx, lui;
   assign sx  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign zx  = {{(OUT_W-IN_W){1'b0}}, imm};
   assign lui = {imm, {(OUT_W-IN_W){1'b0}}};
   assign ext = mode == MODE_SIGN ? sx :
                mode == MODE_ZERO ? zx :
                mode == MODE_LUI  ? lui :
                mode == MODE_BRANCH ? sx << BR_SHIFT : sx;
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate generator behind a 2-entry skid buffer
//   clk, rst_n              clock, async active-low reset
//   flush                   sync squash of all held entries
//   in_valid/in_ready       upstream handshake (in_ready is a flop)
//   in_imm/in_mode/in_tag   immediate, extension mode, sideband tag
//   out_valid/out_ready     downstream handshake
//   out_data/out_tag        extended immediate and its tag (main register)
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);
   state_t state, state_n;
   logic [OUT_W-1:0] ext, skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic accept, take;
   imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT)) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .ext  (ext)
   );
   assign accept = in_valid & in_ready;
   assign take   = out_valid & out_ready;
   always_comb begin
      state_n = flush ? EMPTY :
                state == EMPTY ? (accept ? ONE : EMPTY) :
                state == ONE ? (accept & ~take ? TWO : take & ~accept ? EMPTY : ONE) :
                (take ? ONE : TWO);
   end
   // out_valid and in_ready are registered copies of the next state so no
   // combinational path runs from out_ready to in_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_n;
         out_valid <= state_n != EMPTY;
         in_ready  <= state_n != TWO;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_tag   <= '0;
         skid_data <= '0;
         skid_tag  <= '0;
      end else begin
         if (accept & (state == EMPTY | take)) begin
            out_data <= ext;
            out_tag  <= in_tag;
         end else if (state == TWO & take) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
         end
         if (accept & state == ONE & ~take) begin
            skid_data <= ext;
            skid_tag  <= in_tag;
         end
      end
   end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: vector table, handshake corner sequences and random queue-model check
module tb_imm_extend_pipe;
   logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [15:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic [4:0]  in_tag = '0, out_tag;
   logic [31:0] out_data;
   int errors = 0, checks = 0;
   typedef struct {logic [31:0] d; logic [4:0] t;} ent_t;
   ent_t q[$];
   typedef struct {logic [15:0] imm; logic [1:0] mode; logic [31:0] exp;} vec_t;
   vec_t vecs[6];
   always #5 clk = ~clk;
   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );
   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
      logic [31:0] s;
      s = 32'($signed(imm));
      case (mode)
         2'd0: return s;
         2'd1: return 32'(imm);
         2'd2: return 32'(imm) * 32'd65536;
         default: return s * 32'd4;
      endcase
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      logic acc, tk, fl;
      ent_t e;
      acc = in_valid & in_ready;
      tk  = out_valid & out_ready;
      fl  = flush;
      e.d = ref_ext(in_imm, in_mode);
      e.t = in_tag;
      @(posedge clk);
      #1;
      if (fl) q.delete();
      else begin
         if (tk && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
   endtask
   task automatic check_model(input string n);
      chk({n, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({n, " in_ready"}, 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         chk({n, " out_data"}, out_data, q[0].d);
         chk({n, " out_tag"}, 32'(out_tag), 32'(q[0].t));
      end
   endtask
   task automatic offer(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
      in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
   endtask
   initial begin
      logic hold;
      logic [31:0] pd;
      logic [4:0] pt;
      vecs[0] = '{16'h8004, 2'd0, 32'hFFFF8004};
      vecs[1] = '{16'h8004, 2'd1, 32'h00008004};
      vecs[2] = '{16'h8004, 2'd2, 32'h80040000};
      vecs[3] = '{16'h8004, 2'd3, 32'hFFFE0010};
      vecs[4] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
      vecs[5] = '{16'h7FFF, 2'd0, 32'h00007FFF};
      #2 rst_n = 1'b0;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset out_tag", 32'(out_tag), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      // vector table, back-to-back with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         offer(vecs[i].imm, vecs[i].mode, 5'(i + 3));
         tick();
         chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d data", i), out_data, vecs[i].exp);
         chk($sformatf("vec%0d tag", i), 32'(out_tag), 32'(i + 3));
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain out_valid", 32'(out_valid), 32'd0);
      // backpressure: A,B accepted, C held, then drained in order
      out_ready = 1'b0;
      offer(16'h0001, 2'd1, 5'd1); tick();
      chk("bp A in_ready", 32'(in_ready), 32'd1);
      offer(16'h0002, 2'd1, 5'd2); tick();
      chk("bp B in_ready", 32'(in_ready), 32'd0);
      offer(16'h0003, 2'd1, 5'd3); tick();
      chk("bp C held in_ready", 32'(in_ready), 32'd0);
      chk("bp head A", out_data, 32'h1);
      out_ready = 1'b1; tick();
      chk("bp out B", out_data, 32'h2);
      tick();
      chk("bp out C", out_data, 32'h3);
      check_model("bp C");
      in_valid = 1'b0; tick();
      chk("bp empty", 32'(out_valid), 32'd0);
      // flush while full with a simultaneous offer
      out_ready = 1'b0;
      offer(16'h0010, 2'd0, 5'd4); tick();
      offer(16'h0020, 2'd0, 5'd5); tick();
      chk("fl full", 32'(in_ready), 32'd0);
      flush = 1'b1; offer(16'h0030, 2'd0, 5'd6); tick();
      flush = 1'b0;
      chk("fl out_valid", 32'(out_valid), 32'd0);
      chk("fl in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0; tick();
      chk("fl not captured", 32'(out_valid), 32'd0);
      // async reset while full
      offer(16'h0040, 2'd0, 5'd7); tick();
      offer(16'h0050, 2'd0, 5'd8); tick();
      in_valid = 1'b0;
      chk("rst pre full", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("rst async out_valid", 32'(out_valid), 32'd0);
      chk("rst async out_data", out_data, 32'd0);
      chk("rst async in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      offer(16'hABCD, 2'd2, 5'd9); tick();
      chk("post-rst valid", 32'(out_valid), 32'd1);
      chk("post-rst data", out_data, 32'hABCD0000);
      in_valid = 1'b0; tick();
      check_model("post-rst drain");
      // random traffic against the queue model
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 31) == 0;
         in_imm    = 16'($urandom);
         in_mode   = 2'($urandom_range(0, 3));
         in_tag    = 5'($urandom_range(0, 31));
         hold = out_valid & ~out_ready & ~flush;
         pd = out_data;
         pt = out_tag;
         tick();
         check_model("rnd");
         if (hold) begin
            chk("rnd stable data", out_data, pd);
            chk("rnd stable tag", 32'(out_tag), 32'(pt));
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
